// File: rtl/some_submodule_pkg.sv
// Shared types and constants for the nibble-stream frame statistics unit.
package some_submodule_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int W_SAMPLE = 4;

    localparam logic [W_SAMPLE-1:0] MAX_RST = '0;
    localparam logic [W_SAMPLE-1:0] MIN_RST = '1;

endpackage

// File: rtl/some_submodule_sat_add.sv
// Purpose: W-bit unsigned saturating adder; ovf flags a clamped result.
// Latency: combinational.
// Backpressure: none.
module sat_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] full;

    assign full = {1'b0, x} + {1'b0, y};
    assign ovf  = full[W];
    assign sum  = full[W] ? {W{1'b1}} : full[W-1:0];

endmodule

// File: rtl/some_submodule.sv
// Purpose: per-frame saturating sum, max, min and overflow of a 4-bit sample stream.
// Latency: results and o_done appear one edge after the edge accepting the last sample.
// Backpressure: none; every sample with a=1 is taken while collecting, gaps are free.
module some_submodule
    import some_submodule_pkg::*;
#(
    parameter int FRAME_LEN = 4,
    parameter int W_SUM     = 8
) (
    input  logic                a,
    input  logic                b,
    input  logic [W_SAMPLE-1:0] c,
    input  logic                i_clk,
    input  logic                resetn,
    output logic [W_SUM-1:0]    o_sum,
    output logic [W_SAMPLE-1:0] o_max,
    output logic [W_SAMPLE-1:0] o_min,
    output logic                o_ovf,
    output logic                o_done,
    output logic                o_busy
);

    localparam int W_CNT = $clog2(FRAME_LEN + 1);

    state_t              state;
    logic [W_SUM-1:0]    acc;
    logic [W_SAMPLE-1:0] lmax;
    logic [W_SAMPLE-1:0] lmin;
    logic                lovf;
    logic [W_CNT-1:0]    cnt;

    logic                collecting;
    logic                take;
    logic                last;
    logic [W_SUM-1:0]    acc_in;
    logic [W_SAMPLE-1:0] max_in;
    logic [W_SAMPLE-1:0] min_in;
    logic                ovf_in;
    logic [W_CNT-1:0]    cnt_in;
    logic [W_SUM-1:0]    sat_sum;
    logic                sat_ovf;
    logic [W_SUM-1:0]    acc_n;
    logic [W_SAMPLE-1:0] max_n;
    logic [W_SAMPLE-1:0] min_n;
    logic                ovf_n;
    logic [W_CNT-1:0]    cnt_n;

    // A start pulse wins in every state: the live set is rebuilt from reset values
    // and a coincident sample becomes the first sample of the new frame.
    assign collecting = b || (state == ACCUM);
    assign take       = a && collecting;

    assign acc_in = b ? '0      : acc;
    assign max_in = b ? MAX_RST : lmax;
    assign min_in = b ? MIN_RST : lmin;
    assign ovf_in = b ? 1'b0    : lovf;
    assign cnt_in = b ? '0      : cnt;

    sat_add #(
        .W (W_SUM)
    ) u_sat_add (
        .x   (acc_in),
        .y   (W_SUM'(c)),
        .sum (sat_sum),
        .ovf (sat_ovf)
    );

    always_comb begin
        acc_n = acc_in;
        max_n = max_in;
        min_n = min_in;
        ovf_n = ovf_in;
        cnt_n = cnt_in;
        if (take) begin
            acc_n = sat_sum;
            ovf_n = ovf_in | sat_ovf;
            cnt_n = cnt_in + W_CNT'(1);
            if (c > max_in) max_n = c;
            if (c < min_in) min_n = c;
        end
    end

    assign last = take && (cnt_n == W_CNT'(FRAME_LEN));

    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            acc    <= '0;
            lmax   <= MAX_RST;
            lmin   <= MIN_RST;
            lovf   <= 1'b0;
            cnt    <= '0;
            o_sum  <= '0;
            o_max  <= MAX_RST;
            o_min  <= MIN_RST;
            o_ovf  <= 1'b0;
            o_done <= 1'b0;
            o_busy <= 1'b0;
        end else begin
            // DONE publishes the frame held in the live set; these reads see the
            // pre-edge values even if a new frame starts on this same edge.
            o_done <= (state == DONE);
            if (state == DONE) begin
                o_sum <= acc;
                o_max <= lmax;
                o_min <= lmin;
                o_ovf <= lovf;
            end

            if (collecting) begin
                acc    <= acc_n;
                lmax   <= max_n;
                lmin   <= min_n;
                lovf   <= ovf_n;
                cnt    <= cnt_n;
                state  <= last ? DONE : ACCUM;
                o_busy <= !last;
            end else begin
                state  <= IDLE;
                o_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_some_submodule.sv
// Directed bench for some_submodule: an 8-bit-sum and a 5-bit-sum instance share one stimulus.
module tb_some_submodule;

    logic       i_clk = 1'b0;
    logic       resetn = 1'b0;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic [3:0] c = 4'h0;

    logic [7:0] sum8;
    logic [3:0] max8, min8;
    logic       ovf8, done8, busy8;
    logic [4:0] sum5;
    logic [3:0] max5, min5;
    logic       ovf5, done5, busy5;

    int errors = 0;
    int checks = 0;
    int saw_done;
    int saw_busy;

    always #5 i_clk = ~i_clk;

    some_submodule #(.FRAME_LEN(4), .W_SUM(8)) u_dut8 (
        .a(a), .b(b), .c(c), .i_clk(i_clk), .resetn(resetn),
        .o_sum(sum8), .o_max(max8), .o_min(min8), .o_ovf(ovf8),
        .o_done(done8), .o_busy(busy8)
    );

    some_submodule #(.FRAME_LEN(4), .W_SUM(5)) u_dut5 (
        .a(a), .b(b), .c(c), .i_clk(i_clk), .resetn(resetn),
        .o_sum(sum5), .o_max(max5), .o_min(min5), .o_ovf(ovf5),
        .o_done(done5), .o_busy(busy5)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        if (done8) saw_done++;
        if (busy8) saw_busy++;
    endtask

    // Start pulse alone, then four samples separated by `gap` idle beats.
    // Returns just after the edge that accepts the fourth sample.
    task automatic send_frame(input logic [3:0] s0, input logic [3:0] s1,
                              input logic [3:0] s2, input logic [3:0] s3,
                              input int gap);
        logic [3:0] s [4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        b = 1'b1; a = 1'b0;
        tick();
        b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 1'b1; c = s[i];
            tick();
            a = 1'b0;
            if (i < 3) for (int g = 0; g < gap; g++) tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_sum", sum8, 0);
        chk("rst_max", max8, 0);
        chk("rst_min", min8, 4'hF);
        chk("rst_ovf", ovf8, 0);
        chk("rst_done", done8, 0);
        chk("rst_busy", busy8, 0);
        resetn = 1'b1;
        tick();

        // Samples without a start pulse are ignored.
        saw_done = 0; saw_busy = 0;
        a = 1'b1; c = 4'hF;
        repeat (10) tick();
        a = 1'b0;
        tick();
        chk("idle_busy_seen", saw_busy, 0);
        chk("idle_done_seen", saw_done, 0);
        chk("idle_sum", sum8, 0);
        chk("idle_min", min8, 4'hF);
        chk("idle_max", max8, 0);

        // Back-to-back frame 3,5,1,7.
        send_frame(4'd3, 4'd5, 4'd1, 4'd7, 0);
        chk("f1_busy_after_last", busy8, 0);
        chk("f1_done_early", done8, 0);
        tick();
        chk("f1_done", done8, 1);
        chk("f1_sum", sum8, 16);
        chk("f1_max", max8, 7);
        chk("f1_min", min8, 1);
        chk("f1_ovf", ovf8, 0);
        tick();
        chk("f1_done_one_cycle", done8, 0);
        chk("f1_sum_hold", sum8, 16);

        // Same frame with two idle beats between samples.
        saw_done = 0;
        send_frame(4'd3, 4'd5, 4'd1, 4'd7, 2);
        chk("f2_done_early", saw_done, 0);
        chk("f2_busy_after_last", busy8, 0);
        tick();
        chk("f2_done", done8, 1);
        chk("f2_sum", sum8, 16);
        chk("f2_max", max8, 7);
        chk("f2_min", min8, 1);
        tick();

        // Saturation on the 5-bit sum, none on the 8-bit sum.
        send_frame(4'hF, 4'hF, 4'hF, 4'hF, 0);
        tick();
        chk("sat5_done", done5, 1);
        chk("sat5_sum", sum5, 31);
        chk("sat5_ovf", ovf5, 1);
        chk("sat8_sum", sum8, 60);
        chk("sat8_ovf", ovf8, 0);
        chk("sat_max", max8, 4'hF);
        tick();
        send_frame(4'd1, 4'd1, 4'd1, 4'd1, 1);
        tick();
        chk("post_sat5_sum", sum5, 4);
        chk("post_sat5_ovf", ovf5, 0);
        chk("post_sat8_min", min8, 1);
        tick();

        // Restart: two nines discarded, coincident sample counts as first.
        saw_done = 0;
        b = 1'b1; a = 1'b0;
        tick();
        b = 1'b0; a = 1'b1; c = 4'd9;
        tick();
        tick();
        b = 1'b1; c = 4'd2;
        tick();
        b = 1'b0;
        tick();
        tick();
        chk("rs_busy_mid", busy8, 1);
        tick();
        a = 1'b0;
        chk("rs_no_done", saw_done, 0);
        chk("rs_max_unchanged", max8, 1);
        tick();
        chk("rs_done", done8, 1);
        chk("rs_sum", sum8, 8);
        chk("rs_max", max8, 2);
        chk("rs_min", min8, 2);
        chk("rs_sum5", sum5, 8);
        tick();

        // Asynchronous reset between edges clears outputs at once.
        b = 1'b1;
        tick();
        b = 1'b0; a = 1'b1; c = 4'd4;
        tick();
        tick();
        a = 1'b0;
        chk("ar_busy_before", busy8, 1);
        #2 resetn = 1'b0;
        #1;
        chk("ar_busy", busy8, 0);
        chk("ar_sum", sum8, 0);
        chk("ar_max", max8, 0);
        chk("ar_min", min8, 4'hF);
        @(negedge i_clk);
        resetn = 1'b1;
        tick();
        send_frame(4'd4, 4'd4, 4'd4, 4'd4, 0);
        tick();
        chk("ar_frame_done", done8, 1);
        chk("ar_frame_sum", sum8, 16);
        chk("ar_frame_max", max8, 4);
        chk("ar_frame_min", min8, 4);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
